rf_alu_sequencer: RTL and testbench
===================================

Name: rf_alu_sequencer

Overview:
Multi-cycle initiator that drives the 4x8 register file's ports: two read-select outputs, two read-data inputs, and a write port.
- Accepts one instruction per valid/ready handshake: opcode, destination, two sources, immediate.
- Reads both source registers, computes one ALU result, writes it back with a single-cycle write strobe.
- Sits between a top-level command source (switch/key UI or small ROM) and the register file on the DE10-Lite.

Parameters:
DATA_W, 8, register/data width
ADDR_W, 2, register select width (2^ADDR_W registers)

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept instruction
instr_op  in  3  opcode (see Behaviour)
instr_rd  in  ADDR_W  destination register
instr_rs1  in  ADDR_W  source register 1
instr_rs2  in  ADDR_W  source register 2
instr_imm  in  DATA_W  immediate for LDI
regA  out  ADDR_W  read select A to register file
regB  out  ADDR_W  read select B to register file
dataA  in  DATA_W  combinational read data A
dataB  in  DATA_W  combinational read data B
RFWrite  out  1  write strobe to register file
regW  out  ADDR_W  write select
dataW  out  DATA_W  write data
done  out  1  one-cycle pulse at write-back
busy  out  1  high in any state except IDLE
flag_z  out  1  last result == 0
flag_c  out  1  last carry/borrow/shift-out

Behaviour:
- Reset (async, resetn=0): state=IDLE; all latched fields 0; regA=regB=regW=0, dataW=0, RFWrite=0, done=0, flag_z=0, flag_c=0. RFWrite must drop immediately on reset assertion, even mid-WB.
- Opcodes: 000 NOP, 001 ADD, 010 SUB (rs1-rs2), 011 AND, 100 OR, 101 XOR, 110 SHL (rs1<<1), 111 LDI (imm).
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch op/rd/rs1/rs2/imm; next state READ.
  - instr_valid without ready is ignored; inputs may change freely in other states.
- READ:
  - regA=rs1, regB=rs2 (registered, from latched fields).
  - Capture dataA/dataB into operand registers at end of cycle.
- EXEC:
  - Compute a DATA_W+1-bit result from the captured operands; latch result and carry.
  - ADD carry = bit DATA_W of the sum.
  - SUB: flag_c=1 on borrow (rs1<rs2 unsigned); result mod 2^DATA_W.
  - SHL: flag_c = old bit DATA_W-1; bit 0 = 0.
  - AND/OR/XOR/LDI: flag_c=0.
- WB:
  - regW=rd, dataW=result, done=1 for exactly this cycle.
  - RFWrite=1 for exactly this cycle, except NOP, where RFWrite stays 0.
  - flag_z/flag_c update at the end of WB (NOP leaves them unchanged).
  - Next state IDLE.
- Latency: accept at cycle N; RFWrite/done high in cycle N+3; next accept earliest in cycle N+4. Throughput is one instruction per 4 cycles.
- rd equal to rs1/rs2 is legal. Operands are captured in READ, so the write in WB does not disturb them.
- regA/regB hold their last values outside READ. regW/dataW hold their last values outside WB. Only RFWrite qualifies a write.
- No pipelining and no back-to-back bypass: the register-file write lands at the WB clock edge, before the next READ.

Decomposition:
- Shared package rf_pkg holds:
  - DATA_W/ADDR_W defaults
  - opcode localparams (OP_NOP … OP_LDI)
  - FSM state encodings (S_IDLE, S_READ, S_EXEC, S_WB)
- One natural sub-module, rf_alu: purely combinational. Inputs op, a, b, imm. Outputs DATA_W-bit result and carry.
- The FSM, handshake, and write-back stay in rf_alu_sequencer.

Test Plan:
- Setup for all scenarios: bench instantiates the sequencer with the register file.
- LDI sequence: LDI r0=0x05, LDI r1=0x03. Expect RFWrite pulses with regW=0 dataW=0x05, then regW=1 dataW=0x03, each 3 cycles after accept. flag_z=0, flag_c=0.
- Arithmetic:
  - ADD r2=r0+r1 -> dataW=0x08, flag_c=0.
  - With r0=0xFF, r1=0x01: ADD -> dataW=0x00, flag_c=1, flag_z=1.
  - SUB r3=r1-r0 (0x03-0x05) -> dataW=0xFE, flag_c=1.
- Logic/shift and aliasing:
  - SHL r0=r0<<1 with r0=0x81 -> dataW=0x02, flag_c=1. Read-back shows r0=0x02.
  - XOR r1=r1^r1 -> 0x00, flag_z=1.
- Handshake/NOP:
  - Hold instr_valid high continuously -> instr_ready high only in IDLE; accepts spaced exactly 4 cycles.
  - NOP -> done pulses, RFWrite stays 0, flags unchanged.
- Reset mid-operation: assert resetn=0 during WB of ADD. Expect RFWrite=0 and done=0 immediately (same cycle, asynchronous), state IDLE, instr_ready=1 after release, all outputs at reset values.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, opcodes and sequencer state encodings for the register-file ALU sequencer.
package rf_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;
endpackage

// File: rtl/rf_alu.sv
// Combinational ALU: one DATA_W-bit result plus carry/borrow/shift-out.
module rf_alu
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);
  logic [DATA_W:0] w_wide;

  always_comb begin
    w_wide = '0;
    unique case (i_op)
      OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
      // Bit DATA_W of the extended difference is the unsigned borrow.
      OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
      OP_AND:  w_wide = {1'b0, i_a & i_b};
      OP_OR:   w_wide = {1'b0, i_a | i_b};
      OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
      OP_SHL:  w_wide = {i_a, 1'b0};
      OP_LDI:  w_wide = {1'b0, i_imm};
      default: w_wide = '0;
    endcase
  end

  assign o_result = w_wide[DATA_W-1:0];
  assign o_carry  = w_wide[DATA_W];
endmodule

// File: rtl/rf_alu_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WB sequencer driving a register file's read and write ports.
module rf_alu_sequencer
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] regA,
  output logic [ADDR_W-1:0] regB,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic              RFWrite,
  output logic [ADDR_W-1:0] regW,
  output logic [DATA_W-1:0] dataW,
  output logic              done,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c
);
  state_t              r_state, w_next;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_imm, r_opa, r_opb;
  logic                r_carry;
  logic [DATA_W-1:0]   w_result;
  logic                w_carry;
  logic                w_accept;

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (r_op),
    .i_a      (r_opa),
    .i_b      (r_opb),
    .i_imm    (r_imm),
    .o_result (w_result),
    .o_carry  (w_carry)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) w_next = S_READ;
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = instr_ready && instr_valid;

  // Read selects are loaded at accept so they are stable for the whole READ cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_op    <= OP_NOP;
      r_rd    <= '0;
      r_imm   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      regA    <= '0;
      regB    <= '0;
      regW    <= '0;
      dataW   <= '0;
      RFWrite <= 1'b0;
      done    <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= instr_op;
          r_rd  <= instr_rd;
          r_imm <= instr_imm;
          regA  <= instr_rs1;
          regB  <= instr_rs2;
        end
        S_READ: begin
          r_opa <= dataA;
          r_opb <= dataB;
        end
        S_EXEC: begin
          dataW   <= w_result;
          regW    <= r_rd;
          r_carry <= w_carry;
          RFWrite <= (r_op != OP_NOP);
          done    <= 1'b1;
        end
        default: begin
          RFWrite <= 1'b0;
          done    <= 1'b0;
          if (r_op != OP_NOP) begin
            flag_z <= (dataW == '0);
            flag_c <= r_carry;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench: sequencer plus a behavioural 4x8 register file, directed instruction stream.
module tb_rf_alu_sequencer;
  import rf_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op  = '0;
  logic [1:0] instr_rd  = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [7:0] instr_imm = '0;
  logic [1:0] regA, regB, regW;
  logic [7:0] dataA, dataB, dataW;
  logic       RFWrite, done, busy, flag_z, flag_c;

  logic [7:0] rf [4] = '{default: 8'h00};
  assign dataA = rf[regA];
  assign dataB = rf[regB];
  always @(posedge CLOCK_50) if (RFWrite) rf[regW] <= dataW;

  rf_alu_sequencer dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .regA(regA), .regB(regB), .dataA(dataA), .dataB(dataB),
    .RFWrite(RFWrite), .regW(regW), .dataW(dataW),
    .done(done), .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int         acc;
    logic       wr;
    logic [1:0] rd;
    logic [7:0] d;
    logic       z;
    logic       c;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int prev_acc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops an expectation at each done pulse, then checks flags one cycle later.
  logic flag_pend = 1'b0;
  exp_t cur;
  always @(negedge CLOCK_50) begin
    if (flag_pend) begin
      chk("flag_z", flag_z, cur.z);
      chk("flag_c", flag_c, cur.c);
      flag_pend = 1'b0;
    end
    if (RFWrite && !done) chk("rfwrite_without_done", 1, 0);
    if (done && resetn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("done_latency", cyc - cur.acc, 3);
        chk("rfwrite", RFWrite, cur.wr);
        if (cur.wr) begin
          chk("regW", regW, cur.rd);
          chk("dataW", dataW, cur.d);
        end
        flag_pend = 1'b1;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, input bit gap,
                       input bit push, input logic [7:0] d, input logic z, input logic c,
                       output int acc);
    int t;
    exp_t e;
    @(negedge CLOCK_50);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    acc = cyc;
    if (gap) chk("accept_spacing", acc - prev_acc, 4);
    prev_acc = acc;
    if (push) begin
      e.acc = acc; e.wr = (op != OP_NOP); e.rd = rd; e.d = d; e.z = z; e.c = c;
      exp_q.push_back(e);
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drop_valid(input int n);
    @(negedge CLOCK_50);
    instr_valid = 1'b0;
    repeat (n) @(negedge CLOCK_50);
  endtask

  int a;
  int t;
  initial begin
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {RFWrite, done, flag_z, flag_c, regA, regB, regW, dataW}, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    // Continuously valid: accepts must land exactly 4 cycles apart.
    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h05, 0, 1, 8'h05, 0, 0, a);
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h03, 1, 1, 8'h03, 0, 0, a);
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 8'hAA, 1, 1, 8'h08, 0, 0, a);
    issue(OP_SUB, 2'd3, 2'd1, 2'd0, 8'h00, 1, 1, 8'hFE, 0, 1, a);
    drop_valid(3);

    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hFF, 0, 1, 8'hFF, 0, 0, a);
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h01, 1, 1, 8'h01, 0, 0, a);
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 1, 1, 8'h00, 1, 1, a);
    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h81, 1, 1, 8'h81, 0, 0, a);
    issue(OP_SHL, 2'd0, 2'd0, 2'd3, 8'h00, 1, 1, 8'h02, 0, 1, a);
    drop_valid(2);
    issue(OP_XOR, 2'd1, 2'd1, 2'd1, 8'h00, 0, 1, 8'h00, 1, 0, a);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h00, 1, 1, 8'h00, 1, 0, a);
    issue(OP_NOP, 2'd3, 2'd0, 2'd0, 8'h77, 1, 1, 8'h00, 1, 0, a);
    issue(OP_SUB, 2'd3, 2'd1, 2'd0, 8'h00, 1, 1, 8'hFE, 0, 1, a);
    drop_valid(1);

    t = 0;
    while ((exp_q.size() != 0 || flag_pend) && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    chk("rf_r0_after_shl", rf[0], 8'h02);
    chk("rf_r1_after_xor", rf[1], 8'h00);
    chk("rf_r3_after_nop", rf[3], 8'hFE);

    // Reset asserted in the middle of the write-back cycle of ADD r2=r0+r1 (would write 0x02).
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 0, 0, 8'h00, 0, 0, a);
    instr_valid = 1'b0;
    t = 0;
    while (cyc != a + 3 && t < 10) begin
      @(posedge CLOCK_50);
      #2;
      t++;
    end
    chk("wb_reached", RFWrite, 1);
    resetn = 1'b0;
    #1;
    chk("async_rfwrite", RFWrite, 0);
    chk("async_done", done, 0);
    chk("async_outs", {flag_z, flag_c, regA, regB, regW, dataW}, 0);
    chk("async_idle", {busy, instr_ready}, 2'b01);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("rf_r2_not_written", rf[2], 8'h00);
    repeat (4) @(negedge CLOCK_50);
    chk("post_rst_no_done", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, limit 100000 ns");
    $fatal(1, "timeout");
  end
endmodule
